// File: rtl/monitor_bus_pkg.sv
// rtl/monitor_bus_pkg.sv - shared state encoding and parameter defaults for the monitor bus master
//
// Purpose: one place for the controller state type and the default transfer
// length width / read-return buffer depth used by the master and its bench.
package monitor_bus_pkg;

  localparam int LEN_W_DEFAULT    = 8;  // len 0 means 2^LEN_W bytes
  localparam int RD_DEPTH_DEFAULT = 2;  // read-return buffer entries, minimum 2

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/monitor_bus_rdfifo.sv
// rtl/monitor_bus_rdfifo.sv - synchronous read-return FIFO with occupancy count
//
// Purpose: holds bytes returned by the monitor bus until the read stream takes them.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_data     write one entry (caller guarantees space)
//   pop                 drop the head entry (caller guarantees non-empty)
//   head_data           oldest entry, zero when empty
//   count               current number of entries
module monitor_bus_rdfifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/monitor_bus_master.sv
// rtl/monitor_bus_master.sv - command-driven burst master for the monitor CPU bus
//
// Purpose: takes a command (dir, 16-bit start address, length), requests the
// monitor bus, and moves bytes between the bus and the write/read streams.
// Ports:
//   clk, reset_n                              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len   command handshake
//   bus_req/bus_gnt                           bus ownership handshake
//   bus_address/bus_write/bus_wdata/bus_rdata monitor bus (rdata one cycle after address)
//   wr_valid/wr_ready/wr_data                 write-data stream in
//   rd_valid/rd_ready/rd_data                 read-data stream out
//   busy, done                                status, done is a one-cycle pulse
module monitor_bus_master
  import monitor_bus_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEFAULT,
  parameter int RD_DEPTH = RD_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [15:0]      bus_address,
  output logic             bus_write,
  output logic [7:0]       bus_wdata,
  input  logic [7:0]       bus_rdata,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(RD_DEPTH + 1);

  state_t           state;
  logic [15:0]      addr;
  logic [LEN_W:0]   remaining;   // one extra bit so len 0 can hold 2^LEN_W
  logic             is_write;
  logic             in_flight;   // a read was issued last cycle; its data is on bus_rdata now
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W:0]   occupancy;
  logic             rd_pop;
  logic             wr_issue;
  logic             rd_issue;
  logic             issue;
  logic             last_byte;
  logic             drained;

  assign rd_valid = (rd_count != '0);
  assign rd_pop   = rd_valid & rd_ready;

  // Counting the same-cycle pop lets reads stream one per cycle with only two entries.
  assign occupancy = (CNT_W + 1)'(rd_count) + (CNT_W + 1)'(in_flight) - (CNT_W + 1)'(rd_pop);

  assign wr_ready  = (state == ST_XFER) & is_write & bus_gnt;
  assign wr_issue  = wr_ready & wr_valid;
  assign rd_issue  = (state == ST_XFER) & ~is_write & bus_gnt
                   & (occupancy < (CNT_W + 1)'(RD_DEPTH));
  assign issue     = wr_issue | rd_issue;
  assign last_byte = (remaining == (LEN_W + 1)'(1));
  assign drained   = ~in_flight & (rd_count == CNT_W'(rd_pop));

  assign bus_address = addr;
  assign bus_write   = wr_issue;
  assign bus_wdata   = wr_issue ? wr_data : 8'h00;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign bus_req   = (state == ST_REQ) | (state == ST_XFER) | (state == ST_DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      is_write  <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
            is_write  <= cmd_write;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt) state <= ST_XFER;
        end
        ST_XFER: begin
          if (issue) begin
            addr      <= addr + 16'd1;
            remaining <= remaining - (LEN_W + 1)'(1);
            if (last_byte) state <= is_write ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  monitor_bus_rdfifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (8)
  ) u_rdfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data (bus_rdata),
    .pop       (rd_pop),
    .head_data (rd_data),
    .count     (rd_count)
  );

endmodule
